// File: rtl/age_select_3slot.sv
// age_select_3slot: three-entry holding buffer that ages resident entries
// and presents the oldest one (lowest index on equal age) on a valid/ready port.
// A presented entry that is stalled stays locked until the consumer accepts it.
module age_select_3slot #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AGE_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [1:0]               out_slot,
    output logic [3*AGE_WIDTH-1:0]   ages,
    output logic [1:0]               occupancy
);

    localparam int unsigned N_SLOTS = 3;

    logic [N_SLOTS-1:0]    valid_q, valid_d;
    logic [AGE_WIDTH-1:0]  age_q  [N_SLOTS];
    logic [AGE_WIDTH-1:0]  age_d  [N_SLOTS];
    logic [DATA_WIDTH-1:0] data_q [N_SLOTS];
    logic [DATA_WIDTH-1:0] data_d [N_SLOTS];
    logic                  lock_q, lock_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]            out_slot_q, out_slot_d;
    logic [1:0]            occupancy_q, occupancy_d;
    logic                  in_ready_q, in_ready_d;

    logic                  deq_c;
    logic                  enq_c;
    logic [1:0]            wr_idx_c;
    logic                  wr_found_c;
    logic [1:0]            best_c;
    logic [AGE_WIDTH-1:0]  best_age_c;
    logic                  best_found_c;
    logic [1:0]            sel_c;

    // Next slot state, then the presentation that this next state will show
    always_comb begin
        valid_d      = valid_q;
        age_d        = age_q;
        data_d       = data_q;
        deq_c        = out_valid_q & out_ready;
        enq_c        = 1'b0;
        wr_idx_c     = 2'd0;
        wr_found_c   = 1'b0;
        best_c       = 2'd0;
        best_age_c   = '0;
        best_found_c = 1'b0;
        sel_c        = 2'd0;
        out_data_d   = '0;
        out_slot_d   = 2'd0;

        // Lowest free slot of the pre-edge state; a slot freed this edge is not reused
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!valid_q[i] && !wr_found_c) begin
                wr_idx_c   = 2'(i);
                wr_found_c = 1'b1;
            end
        end
        enq_c = in_valid & in_ready_q & wr_found_c;

        // Age survivors (saturating), retire the accepted slot, write the new entry
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (valid_q[i]) begin
                if (deq_c && (out_slot_q == 2'(i))) begin
                    valid_d[i] = 1'b0;
                    age_d[i]   = '0;
                end else if (age_q[i] != {AGE_WIDTH{1'b1}}) begin
                    age_d[i] = age_q[i] + AGE_WIDTH'(1);
                end
            end
            if (enq_c && (wr_idx_c == 2'(i))) begin
                valid_d[i] = 1'b1;
                age_d[i]   = '0;
                data_d[i]  = in_data;
            end
        end

        occupancy_d = 2'(valid_d[0]) + 2'(valid_d[1]) + 2'(valid_d[2]);
        in_ready_d  = (occupancy_d != 2'd3);
        out_valid_d = (occupancy_d != 2'd0);
        lock_d      = out_valid_q & ~out_ready;

        // Oldest valid slot; strict compare keeps the lowest index on ties
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (valid_d[i] && (!best_found_c || (age_d[i] > best_age_c))) begin
                best_c       = 2'(i);
                best_age_c   = age_d[i];
                best_found_c = 1'b1;
            end
        end
        sel_c = lock_d ? out_slot_q : best_c;

        if (out_valid_d) begin
            out_slot_d = sel_c;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                if (sel_c == 2'(i)) begin
                    out_data_d = data_d[i];
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= '0;
            lock_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_slot_q  <= 2'd0;
            occupancy_q <= 2'd0;
            in_ready_q  <= 1'b1;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                age_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            lock_q      <= lock_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_slot_q  <= out_slot_d;
            occupancy_q <= occupancy_d;
            in_ready_q  <= in_ready_d;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                age_q[i]  <= age_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Pack per-slot ages onto the output bus (empty slots hold age 0)
    always_comb begin
        ages = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            ages[i*AGE_WIDTH +: AGE_WIDTH] = age_q[i];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_slot  = out_slot_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_age_select_3slot.sv
// Testbench for age_select_3slot: directed scenarios then random traffic,
// checked against a birth-time based reference model and a scoreboard of accepted entries.
module tb_age_select_3slot;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 2;
    localparam int          MAX = (1 << AW) - 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_slot;
    logic [3*AW-1:0] ages;
    logic [1:0]      occupancy;

    int checks = 0;
    int errors = 0;

    age_select_3slot #(.DATA_WIDTH(DW), .AGE_WIDTH(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_slot  (out_slot),
        .ages      (ages),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: each slot remembers the edge count at which it was written
    bit          m_v [3];
    logic [7:0]  m_d [3];
    int          m_b [3];
    int          ec;
    bit          m_lock;
    bit          m_ov;
    int          m_slot;
    logic [9:0]  exp_q [$];

    function automatic int m_age(int i);
        if (!m_v[i]) return 0;
        return ((ec - m_b[i]) > MAX) ? MAX : (ec - m_b[i]);
    endfunction

    function automatic int m_cnt();
        return int'(m_v[0]) + int'(m_v[1]) + int'(m_v[2]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_d[i] = '0; m_b[i] = 0;
        end
        ec = 0; m_lock = 1'b0; m_ov = 1'b0; m_slot = 0;
        exp_q.delete();
    endtask

    task automatic model_present();
        int best;
        m_ov = (m_cnt() != 0);
        if (!m_lock) begin
            best = -1;
            for (int i = 0; i < 3; i++)
                if (m_v[i] && (best < 0 || m_age(i) > m_age(best))) best = i;
            m_slot = (best < 0) ? 0 : best;
        end
    endtask

    // Advance the model by one edge using the inputs that were applied at it
    task automatic model_step();
        bit deq, enq;
        int wr;
        deq = m_ov && out_ready;
        enq = in_valid && (m_cnt() != 3);
        wr = -1;
        for (int i = 2; i >= 0; i--) if (!m_v[i]) wr = i;
        ec++;
        if (deq) m_v[m_slot] = 1'b0;
        if (enq && wr >= 0) begin
            m_v[wr] = 1'b1; m_d[wr] = in_data; m_b[wr] = ec;
        end
        m_lock = m_ov && !out_ready;
        model_present();
    endtask

    task automatic apply(input bit iv, input logic [7:0] id, input bit ordy);
        in_valid = iv; in_data = id; out_ready = ordy;
        if (m_ov && ordy) exp_q.push_back({2'(m_slot), m_d[m_slot]});
        @(posedge clk);
        #1;
        if (reset_n) model_step();
    endtask

    // Async reset dropped between edges; outputs must clear immediately
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_occupancy", int'(occupancy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_slot", int'(out_slot), 0);
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compare visible state every cycle and accepted entries against the scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        check("occupancy", int'(occupancy), m_cnt());
        check("in_ready", int'(in_ready), int'(m_cnt() != 3));
        check("out_valid", int'(out_valid), int'(m_ov));
        check("out_slot", int'(out_slot), m_ov ? m_slot : 0);
        check("out_data", int'(out_data), m_ov ? int'(m_d[m_slot]) : 0);
        for (int i = 0; i < 3; i++)
            check("age", int'(ages[i*AW +: AW]), m_age(i));
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("acc_slot", int'(out_slot), int'(e[9:8]));
                check("acc_data", int'(out_data), int'(e[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fill A,B,C while stalled, let ages saturate, then drain in order
        apply(1, 8'h11, 0); apply(1, 8'h22, 0); apply(1, 8'h33, 0);
        check("ages_after_fill", int'(ages), (0 << (2*AW)) | (1 << AW) | 2);
        repeat (5) apply(0, 8'h00, 0);
        repeat (3) apply(0, 8'h00, 1);

        // Full with in_valid and out_ready: only the dequeue happens, 0x44 lands next cycle
        apply(1, 8'h11, 0); apply(1, 8'h22, 0); apply(1, 8'h33, 0);
        apply(1, 8'h44, 1);
        apply(1, 8'h44, 0);
        repeat (4) apply(0, 8'h00, 1);

        // Refill a middle slot
        apply(1, 8'h11, 0); apply(1, 8'h22, 0); apply(1, 8'h33, 0);
        apply(0, 8'h00, 1);
        apply(1, 8'h66, 0);
        apply(0, 8'h00, 1);
        apply(1, 8'h55, 0);
        repeat (3) apply(0, 8'h00, 1);

        // Reset while full and locked
        apply(1, 8'hA1, 0); apply(1, 8'hA2, 0); apply(1, 8'hA3, 0);
        repeat (2) apply(0, 8'h00, 0);
        async_reset();
        apply(0, 8'h00, 0);

        // Random traffic, stalls biased long enough to hit saturation ties under lock
        for (int n = 0; n < 3000; n++) begin
            apply(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3));
        end

        for (int n = 0; n < 10 && m_cnt() != 0; n++) apply(0, 8'h00, 1);
        apply(0, 8'h00, 0);
        check("final_empty", m_cnt(), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
